// File: rtl/counter_sched.sv
// Gated, bounded up-counter controller: start/stop/pause, one-shot or
// auto-reload, with a prescaler that paces increments every presc+1 clocks.
module counter_sched #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tc,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]   lim_q, lim_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               mode_q, mode_d;
  logic               tc_q, tc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               enable_s;

  assign enable_s = (pcnt_q == presc_q);

  // Next-state and datapath decode; stop outranks start, start outranks pause.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    lim_d   = lim_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      count_d = {WIDTH{1'b0}};
      pcnt_d  = {PRESC_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            lim_d   = limit;
            presc_d = presc;
            mode_d  = mode;
            count_d = {WIDTH{1'b0}};
            pcnt_d  = {PRESC_W{1'b0}};
            state_d = S_RUN;
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (enable_s) begin
            pcnt_d = {PRESC_W{1'b0}};
            if (count_q == lim_q) begin
              tc_d = 1'b1;
              if (mode_q) begin
                count_d = {WIDTH{1'b0}};
              end else begin
                state_d = S_DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            pcnt_d = pcnt_q + PRESC_W'(1);
          end
        end
        S_PAUSE: begin
          // Resume edge only changes state; the prescaler picks up where it froze.
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = {WIDTH{1'b0}};
          pcnt_d  = {PRESC_W{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= {WIDTH{1'b0}};
      pcnt_q  <= {PRESC_W{1'b0}};
      lim_q   <= {WIDTH{1'b0}};
      presc_q <= {PRESC_W{1'b0}};
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      lim_q   <= lim_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed scenarios plus random
// stimulus against a model that derives count from elapsed active clocks.
module tb_counter_sched;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, pause, mode;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   count;
  logic               busy, tc, done;
  logic [1:0]         state;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: phase 0 idle, 1 run, 2 pause, 3 done; t = un-paused run clocks.
  int m_st, m_t, m_lim, m_presc, m_mode, m_tc;

  counter_sched #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .limit(limit), .presc(presc), .count(count), .busy(busy),
    .tc(tc), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int exp_count();
    int k;
    if (m_st == 0) return 0;
    k = m_t / (m_presc + 1);
    if (m_mode != 0) return k % (m_lim + 1);
    return (k < m_lim) ? k : m_lim;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_lim = 0; m_presc = 0; m_mode = 0; m_tc = 0;
  endtask

  task automatic model_edge();
    m_tc = 0;
    if (stop) begin
      m_st = 0; m_t = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (start) begin
        m_lim = int'(limit); m_presc = int'(presc); m_mode = int'(mode);
        m_t = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (pause) m_st = 2;
      else begin
        m_t++;
        if (m_t % (m_presc + 1) == 0 && (m_t / (m_presc + 1)) % (m_lim + 1) == 0) begin
          m_tc = 1;
          if (m_mode == 0) m_st = 3;
        end
      end
    end else if (!pause) begin
      m_st = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_st));
    chk("count", 32'(count), 32'(exp_count()));
    chk("busy",  32'(busy),  32'((m_st == 1 || m_st == 2) ? 1 : 0));
    chk("done",  32'(done),  32'((m_st == 3) ? 1 : 0));
    chk("tc",    32'(tc),    32'(m_tc));
  endtask

  task automatic step(input logic i_start, input logic i_stop, input logic i_pause);
    start = i_start; stop = i_stop; pause = i_pause;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int l, input int p, input int md);
    limit = WIDTH'(l); presc = PRESC_W'(p); mode = md[0];
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg(0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1; check_all();
    @(negedge clk); rst_n = 1'b1;
    idle_steps(3);

    // One-shot, limit 5
    cfg(5, 0, 0); step(1'b1, 1'b0, 1'b0);
    idle_steps(9);

    // Reload with prescale 2, limit 3: a few full periods
    cfg(3, 2, 1); step(1'b1, 1'b0, 1'b0);
    idle_steps(30);
    step(1'b0, 1'b1, 1'b0);

    // Pause then stop
    cfg(9, 0, 0); step(1'b1, 1'b0, 1'b0);
    idle_steps(4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    idle_steps(2);
    step(1'b0, 1'b1, 1'b0);
    idle_steps(2);

    // limit 0 one-shot, then limit 0 reload
    cfg(0, 0, 0); step(1'b1, 1'b0, 1'b0); idle_steps(3);
    cfg(0, 1, 1); step(1'b1, 1'b0, 1'b0); idle_steps(6);
    step(1'b0, 1'b1, 1'b0);

    // limit 15 reload wraps to 0; mid-run limit/mode changes and start are ignored
    cfg(15, 0, 1); step(1'b1, 1'b0, 1'b0);
    idle_steps(5);
    cfg(2, 3, 0);
    step(1'b1, 1'b0, 1'b0);
    idle_steps(14);
    step(1'b0, 1'b1, 1'b0);

    // Stop and start together in DONE
    cfg(1, 0, 0); step(1'b1, 1'b0, 1'b0); idle_steps(3);
    step(1'b1, 1'b1, 1'b0);
    // Restart from DONE
    cfg(2, 0, 0); step(1'b1, 1'b0, 1'b0); idle_steps(3);
    step(1'b1, 1'b0, 1'b0); idle_steps(2);

    // Stop on the would-be terminal edge
    cfg(2, 0, 0); step(1'b1, 1'b0, 1'b0); idle_steps(2);
    step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run at count 3
    cfg(9, 0, 1); step(1'b1, 1'b0, 1'b0); idle_steps(3);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst_n = 1'b1;
    idle_steps(2);

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0), pause);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Programmable controller that sequences a 4-bit-style up counter: start, stop, pause, one-shot or auto-reload operation, and a clock prescaler.
- Latches the terminal value and prescale at start, paces count increments, and flags terminal count.
- Sits between software/control logic and any counting datapath that needs gated, bounded counting with a done/tick indication.

Parameters:
- WIDTH, 4, width of count and limit.
- PRESC_W, 4, width of the prescale value and prescale counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- stop  input  1  abort; honoured in any state.
- pause  input  1  level; while high in RUN/PAUSE, counting freezes.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
- limit  input  WIDTH  terminal count value; latched at start.
- presc  input  PRESC_W  prescale; an increment occurs every presc+1 clocks; latched at start.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSE.
- tc  output  1  one-cycle registered terminal-count pulse.
- done  output  1  level, high in DONE.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, tc=0, done=0, busy=0, prescale counter=0, latched limit/presc/mode=0.
- Input priority per edge is stop > start > pause.
- IDLE or DONE, start=1:
  - Latch limit, presc and mode.
  - Set count=0 and prescale counter=0.
  - Go to RUN. done clears on the same edge.
- RUN, enable generation:
  - enable = (prescale counter == latched presc).
  - On enable, the prescale counter resets to 0; otherwise it increments.
  - With presc=0, enable is true every clock.
- RUN on enable, count != limit: count <= count+1.
- RUN on enable, count == limit: tc <= 1 for exactly one cycle.
  - mode=1: count <= 0 and stay in RUN. Period = (limit+1)*(presc+1) clocks.
  - mode=0: go to DONE. count holds at limit.
- Latency: start sampled at edge E, presc=0 → count=1 after edge E+1 and count=n after edge E+n.
- limit=0:
  - One-shot: tc and DONE on the first enable; count stays 0.
  - Reload: tc on every enable.
- limit=2^WIDTH-1: count reaches all-ones, then returns to 0 in reload mode. Arithmetic never wraps past limit.
- pause=1 in RUN: go to PAUSE on that edge, with no increment on that edge. Count and prescale counter freeze.
- pause=0 in PAUSE: return to RUN. The prescale counter resumes from its frozen value.
- stop=1 in any state: go to IDLE, count=0, prescale counter=0, tc=0. This also applies on the same edge as a would-be terminal count: no tc, no DONE.
- start while RUN or PAUSE: ignored. Changes to limit, presc or mode during a run have no effect.
- DONE: holds count and done until start (immediate restart) or stop (to IDLE).
- tc is high for exactly one cycle per terminal event and never high while in IDLE.
- Reset asserted mid-run: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold rst_n=0 across edges, then release → state=0, count=0, busy=0, done=0, tc=0; count does not move without start.
- One-shot: limit=5, presc=0, mode=0, pulse start → count 1,2,3,4,5 on successive edges; next edge tc=1 for 1 cycle, state=3, done=1, count holds 5.
- Reload with prescale: limit=3, presc=2, mode=1 → count increments every 3 clocks, 0→1→2→3→0; tc pulses every 12 clocks; busy stays 1.
- Pause/stop: limit=9, presc=0 run to count=4, pause 5 cycles → count stays 4, state=2; release → continues 5,6. Then stop → state=0, count=0, tc never asserted.
- Boundaries: limit=0 one-shot → tc and DONE one edge after RUN is entered. limit=15 reload → count 15 then 0. Change limit mid-run → no effect on terminal value. start during RUN → ignored.
- Asynchronous reset mid-run: drop rst_n between clock edges at count=3 → count=0, state=0 immediately. stop and start together in DONE → IDLE.
